i2c_bus_monitor: RTL

- Input conditioner and bus-state tracker for the I2C peripheral.
- Takes raw asynchronous SCL/SDA pad inputs and synchronizes them with the 2-flop synchronizer primitive.
- Applies a programmable glitch filter per line.
- Produces filtered levels, SCL edge pulses, START/STOP pulses and a bus-busy flag for the I2C host/target FSMs.

---
 rtl/i2c_bus_mon_pkg.sv | 8 +
 rtl/i2c_line_filter.sv | 42 ++++
 rtl/prim_flop_2sync.sv | 24 ++
 rtl/i2c_bus_monitor.sv | 93 +++++++++
 4 files changed

// File: rtl/i2c_bus_mon_pkg.sv
// i2c_bus_mon_pkg: shared types and constants for the I2C bus monitor.
package i2c_bus_mon_pkg;

    typedef enum logic {BusIdle, BusBusy} bus_state_e;

    localparam logic LineIdle = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: glitch filter for one synchronized bus line.
module i2c_line_filter
    import i2c_bus_mon_pkg::*;
#(
    parameter int unsigned FiltW = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [FiltW-1:0] thresh_i,
    input  logic             s_i,
    output logic             f_o
);

    logic             f_q, f_d;
    logic [FiltW-1:0] cnt_q, cnt_d;

    // The >= compare lets a lowered threshold take effect immediately.
    always_comb begin
        f_d   = f_q;
        cnt_d = '0;
        if (!en_i) begin
            f_d = s_i;
        end else if (s_i != f_q) begin
            if (cnt_q >= thresh_i) f_d = s_i;
            else cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            f_q   <= LineIdle;
            cnt_q <= '0;
        end else begin
            f_q   <= f_d;
            cnt_q <= cnt_d;
        end
    end

    assign f_o = f_q;

endmodule

// File: rtl/prim_flop_2sync.sv
// prim_flop_2sync: two-flop synchronizer for asynchronous inputs.
module prim_flop_2sync #(
    parameter int unsigned      Width      = 1,
    parameter logic [Width-1:0] ResetValue = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= ResetValue;
            q_o    <= ResetValue;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/i2c_bus_monitor.sv
// i2c_bus_monitor: synchronizes and filters SCL/SDA, decodes edges and
// START/STOP conditions, and tracks whether the bus is busy.
module i2c_bus_monitor
    import i2c_bus_mon_pkg::*;
#(
    parameter int unsigned FiltW = 8,
    parameter int unsigned IdleW = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             scl_i,
    input  logic             sda_i,
    input  logic             filt_en_i,
    input  logic [FiltW-1:0] filt_cycles_i,
    input  logic [IdleW-1:0] idle_cycles_i,
    output logic             scl_o,
    output logic             sda_o,
    output logic             scl_rise_o,
    output logic             scl_fall_o,
    output logic             start_o,
    output logic             stop_o,
    output logic             bus_busy_o
);

    logic [1:0]       sync;
    logic             sp_q, dp_q;
    bus_state_e       state_q, state_d;
    logic [IdleW-1:0] idle_q, idle_d;

    prim_flop_2sync #(
        .Width      (2),
        .ResetValue ({LineIdle, LineIdle})
    ) u_sync (
        .clk_i,
        .rst_ni,
        .d_i ({scl_i, sda_i}),
        .q_o (sync)
    );

    i2c_line_filter #(.FiltW(FiltW)) u_scl_filt (
        .clk_i,
        .rst_ni,
        .en_i     (filt_en_i),
        .thresh_i (filt_cycles_i),
        .s_i      (sync[1]),
        .f_o      (scl_o)
    );

    i2c_line_filter #(.FiltW(FiltW)) u_sda_filt (
        .clk_i,
        .rst_ni,
        .en_i     (filt_en_i),
        .thresh_i (filt_cycles_i),
        .s_i      (sync[0]),
        .f_o      (sda_o)
    );

    assign scl_rise_o = !sp_q && scl_o;
    assign scl_fall_o = sp_q && !scl_o;
    assign start_o    = sp_q && scl_o && dp_q && !sda_o;
    assign stop_o     = sp_q && scl_o && !dp_q && sda_o;
    assign bus_busy_o = state_q == BusBusy;

    // A falling SCL in IDLE means we joined a transfer already in progress.
    always_comb begin
        state_d = state_q;
        idle_d  = '0;
        if (state_q == BusIdle) begin
            state_d = (start_o || scl_fall_o) ? BusBusy : BusIdle;
        end else begin
            idle_d = (scl_o && sda_o) ? ((&idle_q) ? idle_q : idle_q + 1'b1) : '0;
            if (stop_o || (idle_cycles_i != '0 && idle_q == idle_cycles_i)) begin
                state_d = BusIdle;
                idle_d  = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sp_q    <= LineIdle;
            dp_q    <= LineIdle;
            state_q <= BusIdle;
            idle_q  <= '0;
        end else begin
            sp_q    <= scl_o;
            dp_q    <= sda_o;
            state_q <= state_d;
            idle_q  <= idle_d;
        end
    end

endmodule
